// File: rtl/cgra_pkg.sv
// Shared definitions for the CGRA tile: sequencer states, op encoding and the default slice width.
package cgra_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/wide_add_sequencer.sv
// Multi-word add/subtract controller: streams wide operands LSW-first through a WIDTH-bit
// full_adder slice with a one-cycle latency, chaining carries, and assembles the wide result.
module wide_add_sequencer
    import cgra_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int NWORDS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH*NWORDS-1:0]   in_a,
    input  logic [WIDTH*NWORDS-1:0]   in_b,
    input  logic                      in_op,
    input  logic                      in_carry,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH*NWORDS-1:0]   out_sum,
    output logic                      out_carry,
    output logic                      out_ovf,
    output logic                      err,
    output logic [WIDTH-1:0]          add_a,
    output logic [WIDTH-1:0]          add_b,
    output logic                      add_carry_in,
    output logic                      add_carry_listen,
    output logic                      add_on_off,
    input  logic [WIDTH-1:0]          add_c,
    input  logic                      add_carry_out,
    input  logic                      add_ack
);

    localparam int W  = WIDTH * NWORDS;
    localparam int KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NWORDS - 1);

    state_t          state;
    state_t          state_next;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    b_eff;
    logic            c0;
    logic [KW-1:0]   k;
    logic [KW-1:0]   k_next;
    logic            last_slice;
    logic            accept;

    // Subtraction is a + ~b + 1, so only the b operand and the initial carry differ.
    assign b_eff      = (in_op == OP_SUB) ? ~in_b : in_b;
    assign c0         = (in_op == OP_ADD) ? in_carry : 1'b1;
    assign last_slice = (k == K_LAST);
    assign k_next     = k + KW'(1);
    assign accept     = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)   state_next = ISSUE;
            ISSUE:                   state_next = WAIT;
            WAIT:    state_next = last_slice ? DONE : ISSUE;
            DONE:    if (out_ready)  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) && reset;
        out_valid = (state == DONE);
    end

    // Slice operands are loaded on the edge entering ISSUE so they are already stable there.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_reg            <= '0;
            b_reg            <= '0;
            k                <= '0;
            out_sum          <= '0;
            out_carry        <= 1'b0;
            out_ovf          <= 1'b0;
            err              <= 1'b0;
            add_a            <= '0;
            add_b            <= '0;
            add_carry_in     <= 1'b0;
            add_carry_listen <= 1'b0;
            add_on_off       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg            <= in_a;
                        b_reg            <= b_eff;
                        k                <= '0;
                        out_sum          <= '0;
                        out_carry        <= 1'b0;
                        out_ovf          <= 1'b0;
                        add_a            <= in_a[WIDTH-1:0];
                        add_b            <= b_eff[WIDTH-1:0];
                        add_carry_in     <= c0;
                        add_carry_listen <= 1'b1;
                        add_on_off       <= 1'b1;
                    end
                end
                WAIT: begin
                    out_sum[int'(k)*WIDTH +: WIDTH] <= add_c;
                    if (!add_ack) begin
                        err <= 1'b1;
                    end
                    if (last_slice) begin
                        out_carry        <= add_carry_out;
                        out_ovf          <= (a_reg[W-1] == b_reg[W-1]) &&
                                            (add_c[WIDTH-1] != a_reg[W-1]);
                        add_on_off       <= 1'b0;
                        add_carry_listen <= 1'b0;
                    end else begin
                        k            <= k_next;
                        add_a        <= a_reg[int'(k_next)*WIDTH +: WIDTH];
                        add_b        <= b_reg[int'(k_next)*WIDTH +: WIDTH];
                        add_carry_in <= add_carry_out;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer paired with a behavioural one-cycle full_adder.
module tb_wide_add_sequencer;
    import cgra_pkg::*;

    localparam int WIDTH  = 16;
    localparam int NWORDS = 4;
    localparam int W      = WIDTH * NWORDS;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [W-1:0]       in_a = '0;
    logic [W-1:0]       in_b = '0;
    logic               in_op = 1'b0;
    logic               in_carry = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [W-1:0]       out_sum;
    logic               out_carry;
    logic               out_ovf;
    logic               err;
    logic [WIDTH-1:0]   add_a;
    logic [WIDTH-1:0]   add_b;
    logic               add_carry_in;
    logic               add_carry_listen;
    logic               add_on_off;
    logic [WIDTH-1:0]   add_c = '0;
    logic               add_carry_out = 1'b0;
    logic               add_ack = 1'b0;
    logic               nack_mode = 1'b0;

    int checks = 0;
    int failures = 0;

    wide_add_sequencer #(.WIDTH(WIDTH), .NWORDS(NWORDS)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_carry(in_carry),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry(out_carry), .out_ovf(out_ovf), .err(err),
        .add_a(add_a), .add_b(add_b), .add_carry_in(add_carry_in),
        .add_carry_listen(add_carry_listen), .add_on_off(add_on_off),
        .add_c(add_c), .add_carry_out(add_carry_out), .add_ack(add_ack)
    );

    always #5 clk = ~clk;

    // Behavioural full_adder: one-cycle latency, cleared while powered off.
    always @(posedge clk) begin
        if (add_on_off) begin
            {add_carry_out, add_c} <= {1'b0, add_a} + {1'b0, add_b} + 17'(add_carry_in);
            add_ack                <= !nack_mode;
        end else begin
            add_c         <= '0;
            add_carry_out <= 1'b0;
            add_ack       <= 1'b0;
        end
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         op;
        logic         cin;
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
    } vec_t;

    vec_t vecs[7];

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic op, input logic cin,
                                  output logic [W-1:0] s, output logic c, output logic ovf);
        logic [W:0] r;
        if (op == OP_SUB) begin
            r   = {1'b0, a} - {1'b0, b};
            c   = (a >= b);
            ovf = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end else begin
            r   = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            c   = r[W];
            ovf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end
        s = r[W-1:0];
    endfunction

    task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%h expected=0x%h", name, act, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge right after the accept edge.
    task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic op, input logic cin);
        check_output("in_ready_before_accept", W'(in_ready), W'(1));
        in_a = a; in_b = b; in_op = op; in_carry = cin; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = {$urandom, $urandom};
        in_b     = {$urandom, $urandom};
        in_op    = 1'($urandom);
        in_carry = 1'($urandom);
    endtask

    task automatic wait_result(output int lat, output int on_cycles);
        lat = 0;
        on_cycles = 0;
        while (!out_valid && lat < 40) begin
            if (add_on_off) on_cycles++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_op(input int hold);
        logic [W-1:0] held;
        held = out_sum;
        repeat (hold) begin
            in_valid = 1'($urandom);
            @(negedge clk);
            check_output("sum_stable_in_done", out_sum, held);
            check_output("valid_held_in_done", W'(out_valid), W'(1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_output("valid_drop_after_ready", W'(out_valid), W'(0));
        check_output("in_ready_back_idle", W'(in_ready), W'(1));
    endtask

    task automatic run_and_check(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic op, input logic cin,
                                 input logic [W-1:0] exp_sum, input logic exp_carry,
                                 input logic exp_ovf, input int hold);
        int lat;
        int on_cycles;
        apply_stimulus(a, b, op, cin);
        wait_result(lat, on_cycles);
        check_output("latency", W'(lat), W'(2 * NWORDS));
        check_output("on_off_cycles", W'(on_cycles), W'(2 * NWORDS));
        check_output("out_sum", out_sum, exp_sum);
        check_output("out_carry", W'(out_carry), W'(exp_carry));
        check_output("out_ovf", W'(out_ovf), W'(exp_ovf));
        finish_op(hold);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [W-1:0] ms;
        logic         mc;
        logic         mo;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rop;
        logic         rcin;
        int           lat;
        int           on_cycles;

        vecs[0] = '{a: 64'h0000_0000_0000_FFFF, b: 64'h1, op: OP_ADD, cin: 1'b0,
                    sum: 64'h0000_0000_0001_0000, carry: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'h0, op: OP_ADD, cin: 1'b1,
                    sum: 64'h0, carry: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 64'h8000_0000_0000_0000, b: 64'h1, op: OP_SUB, cin: 1'b0,
                    sum: 64'h7FFF_FFFF_FFFF_FFFF, carry: 1'b1, ovf: 1'b1};
        vecs[3] = '{a: 64'h7FFF_FFFF_FFFF_FFFF, b: 64'h1, op: OP_ADD, cin: 1'b0,
                    sum: 64'h8000_0000_0000_0000, carry: 1'b0, ovf: 1'b1};
        vecs[4] = '{a: 64'h0, b: 64'h1, op: OP_SUB, cin: 1'b1,
                    sum: 64'hFFFF_FFFF_FFFF_FFFF, carry: 1'b0, ovf: 1'b0};
        vecs[5] = '{a: 64'h8000_0000_0000_0000, b: 64'h8000_0000_0000_0000, op: OP_ADD, cin: 1'b0,
                    sum: 64'h0, carry: 1'b1, ovf: 1'b1};
        vecs[6] = '{a: 64'h0000_FFFF_0000_FFFF, b: 64'h0000_0001_0000_0001, op: OP_ADD, cin: 1'b1,
                    sum: 64'h0001_0000_0001_0001, carry: 1'b0, ovf: 1'b0};

        repeat (3) @(negedge clk);
        check_output("reset_in_ready", W'(in_ready), W'(0));
        check_output("reset_out_valid", W'(out_valid), W'(0));
        check_output("reset_out_sum", out_sum, W'(0));
        check_output("reset_add_on_off", W'(add_on_off), W'(0));
        check_output("reset_err", W'(err), W'(0));
        reset = 1'b1;
        #1;
        check_output("in_ready_after_release", W'(in_ready), W'(1));
        @(negedge clk);

        $display("[TB] table vectors");
        for (int i = 0; i < 7; i++) begin
            run_and_check(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].cin,
                          vecs[i].sum, vecs[i].carry, vecs[i].ovf, 0);
        end

        $display("[TB] output backpressure");
        apply_stimulus(64'h1234, 64'h1111, OP_ADD, 1'b0);
        wait_result(lat, on_cycles);
        in_a = 64'd5; in_b = 64'd6; in_op = OP_ADD; in_carry = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("bp_sum_stable", out_sum, 64'h2345);
            check_output("bp_in_ready_low", W'(in_ready), W'(0));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_output("bp_idle_after_ready", W'(in_ready), W'(1));
        check_output("bp_valid_dropped", W'(out_valid), W'(0));
        @(negedge clk);
        in_valid = 1'b0;
        check_output("bp_next_accepted", W'(add_on_off), W'(1));
        wait_result(lat, on_cycles);
        check_output("bp_next_latency", W'(lat), W'(2 * NWORDS));
        check_output("bp_next_sum", out_sum, W'(11));
        finish_op(0);

        $display("[TB] reset mid-operation");
        apply_stimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, OP_ADD, 1'b0);
        repeat (5) @(negedge clk);
        check_output("mid_on_before_reset", W'(add_on_off), W'(1));
        reset = 1'b0;
        #1;
        check_output("mid_in_ready", W'(in_ready), W'(0));
        check_output("mid_out_valid", W'(out_valid), W'(0));
        check_output("mid_out_sum", out_sum, W'(0));
        check_output("mid_add_bus", {add_a, add_b, 14'd0, add_carry_in, add_carry_listen}, W'(0));
        check_output("mid_add_on_off", W'(add_on_off), W'(0));
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_output("mid_in_ready_release", W'(in_ready), W'(1));
        @(negedge clk);
        run_and_check(64'd3, 64'd4, OP_ADD, 1'b0, 64'd7, 1'b0, 1'b0, 0);

        $display("[TB] adder nack");
        nack_mode = 1'b1;
        run_and_check(64'h0000_0001_FFFF_0002, 64'h0000_0000_0001_0003, OP_ADD, 1'b0,
                      64'h0000_0002_0000_0005, 1'b0, 1'b0, 0);
        check_output("err_set", W'(err), W'(1));
        nack_mode = 1'b0;
        run_and_check(64'd10, 64'd3, OP_SUB, 1'b0, 64'd7, 1'b1, 1'b0, 0);
        check_output("err_sticky", W'(err), W'(1));
        reset = 1'b0;
        @(negedge clk);
        check_output("err_cleared", W'(err), W'(0));
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] random operations");
        for (int i = 0; i < 40; i++) begin
            ra   = {$urandom, $urandom};
            rb   = (i % 4 == 0) ? ra : {$urandom, $urandom};
            rop  = 1'($urandom);
            rcin = 1'($urandom);
            model(ra, rb, rop, rcin, ms, mc, mo);
            run_and_check(ra, rb, rop, rcin, ms, mc, mo, int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

- Multi-word add/subtract controller that sits directly upstream of the tile's `full_adder` slice.
- Accepts two NWORDS×WIDTH-bit operands on a valid/ready handshake.
- Streams them LSW-first through the WIDTH-bit adder, chaining `carry_out` into the next slice's `carry_in`.
- Assembles the wide result, carry and signed overflow, and presents them on a valid/ready output handshake.

## Interface
- `WIDTH`, 16: adder slice width; must match the downstream `full_adder` parameter.
- `NWORDS`, 4: slices per operation; ≥1. Operand width is W = WIDTH*NWORDS.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand request.
- `in_ready`  out  1  block can accept; high only in IDLE; forced 0 while `reset` is low.
- `in_a`, `in_b`  in  W  operands.
- `in_op`  in  1  0 = add, 1 = subtract (a − b).
- `in_carry`  in  1  carry into slice 0 for add; ignored for subtract.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `out_sum`  out  W  result.
- `out_carry`  out  1  final slice carry; for subtract, 1 = no borrow.
- `out_ovf`  out  1  signed two's-complement overflow of the W-bit result.
- `err`  out  1  sticky; set if `add_ack` is low in any WAIT cycle; cleared only by reset.
- `add_a`, `add_b`  out  WIDTH  slice operands to the adder; registered.
- `add_carry_in`, `add_carry_listen`, `add_on_off`  out  1  adder controls; registered.
- `add_c`  in  WIDTH  adder sum.
- `add_carry_out`, `add_ack`  in  1  adder carry and acknowledge.

## Operation
- **States:** IDLE, ISSUE, WAIT, DONE. Reset enters IDLE.
- **Reset values:** all outputs and registers are 0. That includes `out_*`, `err`, all `add_*` outputs, the slice index and the operand latches.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid` & `in_ready`, latch `in_a` and `in_op`.
  - Latch b_eff = `in_op` ? ~`in_b` : `in_b`.
  - Latch c0 = `in_op` ? 1 : `in_carry`.
  - Set slice index k=0 and go to ISSUE.
  - Clear `out_sum`, `out_carry` and `out_ovf`.
- **ISSUE** (1 cycle)
  - Registers drive `add_a` = a[k], `add_b` = b_eff[k], `add_on_off`=1, `add_carry_listen`=1.
  - `add_carry_in` = c0 for k=0, else the stored carry.
  - Go to WAIT.
- **WAIT** (1 cycle)
  - `add_c` and `add_carry_out` hold slice k's result; capture into `out_sum[k]` and the carry register.
  - If `add_ack`=0, set `err`. The captured data is still used.
  - If k=NWORDS−1: set `out_carry` = `add_carry_out` and `out_ovf` = (a_msb == b_eff_msb) && (`add_c` msb != a_msb). Drop `add_on_off` and go to DONE.
  - Otherwise k++ and go to ISSUE.
- **DONE**
  - `out_valid`=1. `out_sum`, `out_carry` and `out_ovf` stay stable until `out_ready`.
  - On `out_ready`, go to IDLE and drop `out_valid` on the same edge.
- **Adder power:** `add_on_off` is 0 in IDLE and DONE, which holds the adder in its cleared state. Operand outputs hold their last values.
- **Arithmetic:** modulo 2^W. The slice carry is chained exactly; no saturation.
- **Slice order:** slice k = bits [k*WIDTH +: WIDTH], LSW first.

## Timing
- Accept edge E0. Slice k is issued during cycle 2k+1 and captured at edge E(2k+2).
- `out_valid` rises at edge E(2·NWORDS): 8 cycles after acceptance for NWORDS=4, 2 cycles for NWORDS=1.
- Throughput: one operation per 2·NWORDS+2 cycles with `out_ready` tied high. There is an IDLE cycle between operations.
- No input is sampled outside IDLE. `in_a`, `in_b` and `in_op` may change freely after acceptance.
- `out_ready` is ignored outside DONE.
- The adder registers its result one edge after ISSUE. WAIT relies on exactly that 1-cycle adder latency.
- Asynchronous reset mid-operation: every output clears immediately and the state goes to IDLE. The partial result is discarded. `add_on_off`=0 clears the adder on its next clock.

## Structure
- Shared package `cgra_pkg`:
  - state enum (IDLE, ISSUE, WAIT, DONE);
  - op encoding constants (OP_ADD=0, OP_SUB=1);
  - default WIDTH.
- Single module; no sub-module required.
- The slice select/insert can be an indexed part-select on k, which is $clog2(NWORDS) bits wide (minimum 1).

## Test plan
Bench pairs the block with a behavioural 1-cycle `full_adder`; WIDTH=16, NWORDS=4.
1. Add 0x0000_0000_0000_FFFF + 0x1, `in_carry`=0 -> `out_sum`=0x0000_0000_0001_0000, `out_carry`=0, `out_ovf`=0. `out_valid` rises 8 cycles after accept.
2. Add 0xFFFF_FFFF_FFFF_FFFF + 0x0, `in_carry`=1 -> `out_sum`=0, `out_carry`=1, `out_ovf`=0.
3. Subtract 0x8000_0000_0000_0000 − 0x1 -> `out_sum`=0x7FFF_FFFF_FFFF_FFFF, `out_carry`=1, `out_ovf`=1. `add_on_off` is high for exactly 8 cycles.
4. Hold `out_ready` low 5 cycles in DONE -> `out_*` stable, `in_ready`=0, `in_valid` ignored. Then `out_ready`=1 -> IDLE next edge and the next operation is accepted one cycle later.
5. Assert `reset` in the WAIT cycle of slice 2 -> all outputs 0 asynchronously. After release, `in_ready`=1 and a fresh add of 3 + 4 returns 7.
6. Adder stub forces `add_ack`=0 -> `err`=1 and stays 1 across subsequent operations. Results are still correct; only reset clears `err`.
